// File: rtl/otsu_pkg.sv
// Shared constants for the Otsu sweep controller: default sizing and FSM state encodings.
package otsu_pkg;

  localparam int unsigned BINS_DEF    = 256;
  localparam int unsigned BIN_W_DEF   = 8;
  localparam int unsigned COUNT_W_DEF = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_ISSUE   = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_REPORT  = 3'd6;

endpackage

// File: rtl/otsu_sweep_controller_sweep_index_counter.sv
// Nested bin/threshold counter for the Otsu sweep, with terminal-value flags.
// Terminal values are checked by the caller before incrementing, so neither counter wraps in a sweep.
module sweep_index_counter #(
  parameter int unsigned BINS  = otsu_pkg::BINS_DEF,
  parameter int unsigned BIN_W = otsu_pkg::BIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bin_clear,
  input  logic             bin_inc,
  input  logic             thr_clear,
  input  logic             thr_inc,
  output logic [BIN_W-1:0] bin,
  output logic [BIN_W-1:0] thr,
  output logic             bin_last,
  output logic             thr_last
);

  localparam logic [BIN_W-1:0] LAST = BIN_W'(BINS - 1);

  // Bin counter: restarts at every threshold pass.
  always_ff @(posedge clk) begin
    if (reset)          bin <= '0;
    else if (bin_clear) bin <= '0;
    else if (bin_inc)   bin <= bin + 1'b1;
  end

  // Threshold counter: restarts at sweep start and after the final report.
  always_ff @(posedge clk) begin
    if (reset)          thr <= '0;
    else if (thr_clear) thr <= '0;
    else if (thr_inc)   thr <= thr + 1'b1;
  end

  assign bin_last = (bin == LAST);
  assign thr_last = (thr == LAST);

endmodule

// File: rtl/otsu_sweep_controller.sv
// Otsu sweep controller: for each threshold t walks all histogram bins, reads n_i and hands
// (i, n_i, t) to the w0/w1 accumulators, then reports the finished threshold downstream.
// Optional feature: define SKIP_EMPTY_BIN_EN to skip the transfer of bins whose count is zero.
module otsu_sweep_controller
  import otsu_pkg::*;
#(
  parameter int unsigned BINS    = BINS_DEF,
  parameter int unsigned BIN_W   = BIN_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               hist_rd_en,
  output logic [BIN_W-1:0]   hist_rd_addr,
  input  logic [COUNT_W-1:0] hist_rd_data,
  output logic               acc_clear,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [BIN_W-1:0]   bin_i,
  output logic [COUNT_W-1:0] bin_n,
  output logic [BIN_W-1:0]   threshold,
  input  logic               acc_idle,
  output logic               thr_valid,
  input  logic               thr_ack
);

  logic [2:0]       state, state_nxt;
  logic [BIN_W-1:0] bin, thr;
  logic             bin_last, thr_last;
  logic             bin_clear, bin_inc, thr_clear, thr_inc;
  logic             load_payload, done_set;

  sweep_index_counter #(
    .BINS  (BINS),
    .BIN_W (BIN_W)
  ) u_index (
    .clk       (clk),
    .reset     (reset),
    .bin_clear (bin_clear),
    .bin_inc   (bin_inc),
    .thr_clear (thr_clear),
    .thr_inc   (thr_inc),
    .bin       (bin),
    .thr       (thr),
    .bin_last  (bin_last),
    .thr_last  (thr_last)
  );

  // Next-state and counter control decode.
  always_comb begin
    state_nxt    = state;
    bin_clear    = 1'b0;
    bin_inc      = 1'b0;
    thr_clear    = 1'b0;
    thr_inc      = 1'b0;
    load_payload = 1'b0;
    done_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        // done is high only in the first IDLE cycle; a start there is dropped.
        if (start && !done) begin
          state_nxt = ST_CLEAR;
          thr_clear = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_READ;
        bin_clear = 1'b1;
      end
      ST_READ: state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: begin
`ifdef SKIP_EMPTY_BIN_EN
        if (hist_rd_data == '0) begin
          if (bin_last) begin
            state_nxt = ST_DRAIN;
          end else begin
            bin_inc   = 1'b1;
            state_nxt = ST_READ;
          end
        end else begin
          load_payload = 1'b1;
          state_nxt    = ST_ISSUE;
        end
`else
        load_payload = 1'b1;
        state_nxt    = ST_ISSUE;
`endif
      end
      ST_ISSUE: begin
        if (bin_ready) begin
          if (bin_last) begin
            state_nxt = ST_DRAIN;
          end else begin
            bin_inc   = 1'b1;
            state_nxt = ST_READ;
          end
        end
      end
      ST_DRAIN: begin
        if (acc_idle) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (thr_ack) begin
          if (thr_last) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b1;
            thr_clear = 1'b1;
          end else begin
            thr_inc   = 1'b1;
            state_nxt = ST_CLEAR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_set;
    end
  end

  // Transfer payload: captured once per bin, held stable through any back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_i <= '0;
      bin_n <= '0;
    end else if (load_payload) begin
      bin_i <= bin;
      bin_n <= hist_rd_data;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign acc_clear    = (state == ST_CLEAR);
  assign hist_rd_en   = (state == ST_READ);
  assign hist_rd_addr = bin;
  assign bin_valid    = (state == ST_ISSUE);
  assign thr_valid    = (state == ST_REPORT);
  assign threshold    = thr;

endmodule

// File: tb/tb_otsu_sweep_controller.sv
// Scoreboard bench for otsu_sweep_controller with BINS=4 and a histogram of {5,0,7,2}.
module tb_otsu_sweep_controller;

  localparam int BINS    = 4;
  localparam int BIN_W   = 2;
  localparam int COUNT_W = 32;
`ifdef SKIP_EMPTY_BIN_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int PASS_LEN  = SKIP ? 14 : 15;
  localparam int SWEEP_LEN = 4 * PASS_LEN + 1;
  localparam int XFERS     = SKIP ? 12 : 16;

  logic               clk = 1'b0;
  logic               reset, start, busy, done, hist_rd_en, acc_clear;
  logic [BIN_W-1:0]   hist_rd_addr, bin_i, threshold;
  logic [COUNT_W-1:0] hist_rd_data, bin_n;
  logic               bin_valid, bin_ready, acc_idle, thr_valid, thr_ack;

  otsu_sweep_controller #(
    .BINS    (BINS),
    .BIN_W   (BIN_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .hist_rd_en   (hist_rd_en),
    .hist_rd_addr (hist_rd_addr),
    .hist_rd_data (hist_rd_data),
    .acc_clear    (acc_clear),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin_i        (bin_i),
    .bin_n        (bin_n),
    .threshold    (threshold),
    .acc_idle     (acc_idle),
    .thr_valid    (thr_valid),
    .thr_ack      (thr_ack)
  );

  always #5 clk = ~clk;

  logic [COUNT_W-1:0] hist [BINS] = '{32'd5, 32'd0, 32'd7, 32'd2};

  // One-cycle-latency RAM; garbage when not read so stale sampling is visible.
  always @(posedge clk)
    hist_rd_data <= hist_rd_en ? hist[hist_rd_addr] : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [BIN_W-1:0]   t;
    logic [BIN_W-1:0]   i;
    logic [COUNT_W-1:0] n;
  } xfer_t;

  xfer_t exp_q[$];
  int checks = 0, fails = 0;
  int cyc = 0;
  int n_xfer, n_clr, n_thr, n_done, last_clr;
  bit gap_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_xfer = 0; n_clr = 0; n_thr = 0; n_done = 0; last_clr = -1;
  endtask

  task automatic push_sweep();
    for (int t = 0; t < BINS; t++)
      for (int i = 0; i < BINS; i++)
        if (!(SKIP && hist[i] == 0))
          exp_q.push_back('{t: BIN_W'(t), i: BIN_W'(i), n: hist[i]});
  endtask

  // Monitor: scoreboard on transfers, plus pulse counting.
  always @(negedge clk) begin
    if (!reset) begin
      if (bin_valid && bin_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          timeout("xfer_unexpected");
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          chk("xfer_t", 64'(threshold), 64'(e.t));
          chk("xfer_i", 64'(bin_i), 64'(e.i));
          chk("xfer_n", 64'(bin_n), 64'(e.n));
        end
      end
      if (acc_clear) begin
        n_clr++;
        if (gap_chk && last_clr >= 0) chk("pass_len", 64'(cyc - last_clr), 64'(PASS_LEN));
        last_clr = cyc;
      end
      if (thr_valid && thr_ack) n_thr++;
      if (done) n_done++;
    end
  end

  task automatic zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rd_en"}, 64'(hist_rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(hist_rd_addr), 0);
    chk({tag, "_acc_clear"}, 64'(acc_clear), 0);
    chk({tag, "_bin_valid"}, 64'(bin_valid), 0);
    chk({tag, "_bin_i"}, 64'(bin_i), 0);
    chk({tag, "_bin_n"}, 64'(bin_n), 0);
    chk({tag, "_threshold"}, 64'(threshold), 0);
    chk({tag, "_thr_valid"}, 64'(thr_valid), 0);
  endtask

  task automatic pulse_start(output int scyc);
    start = 1'b1;
    scyc  = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    bit found = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dcyc  = cyc;
      end
    end
    if (!found) timeout({tag, "_done"});
  endtask

  task automatic sweep_totals(input string tag);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 0);
    chk({tag, "_done_pulse"}, 64'(done), 0);
    chk({tag, "_xfers"}, 64'(n_xfer), 64'(XFERS));
    chk({tag, "_clears"}, 64'(n_clr), 4);
    chk({tag, "_reports"}, 64'(n_thr), 4);
    chk({tag, "_dones"}, 64'(n_done), 1);
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    int s, d;
    bit found;
    reset = 1'b1; start = 1'b0; bin_ready = 1'b1; acc_idle = 1'b1; thr_ack = 1'b1;
    gap_chk = 1'b0;
    clr_counts();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    zero_outputs("reset");
    tick();

    // Free-running sweep: order, payload, pass length, start-to-done latency.
    clr_counts(); gap_chk = 1'b1;
    push_sweep();
    pulse_start(s);
    wait_done("t1", d);
    chk("t1_latency", 64'(d - s), 64'(SWEEP_LEN));
    sweep_totals("t1");
    gap_chk = 1'b0;
    tick();

    // Back-pressure on (t=1, i=2): payload frozen, single transfer.
    clr_counts();
    push_sweep();
    pulse_start(s);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (hist_rd_en && threshold == 2'd1 && hist_rd_addr == 2'd2) found = 1'b1;
    end
    if (!found) timeout("t2_find");
    tick();
    bin_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_valid", 64'(bin_valid), 1);
      chk("t2_bin_i", 64'(bin_i), 2);
      chk("t2_bin_n", 64'(bin_n), 7);
      chk("t2_thr", 64'(threshold), 1);
      tick();
    end
    bin_ready = 1'b1;
    wait_done("t2", d);
    sweep_totals("t2");
    tick();

    // Drain and report stalls on threshold 0.
    clr_counts();
    acc_idle = 1'b0; thr_ack = 1'b0;
    push_sweep();
    pulse_start(s);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bin_valid && bin_ready && threshold == 2'd0 && bin_i == 2'd3) found = 1'b1;
    end
    if (!found) timeout("t3_find");
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_drain_thr_valid", 64'(thr_valid), 0);
      chk("t3_drain_busy", 64'(busy), 1);
      tick();
    end
    acc_idle = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_report_valid", 64'(thr_valid), 1);
      chk("t3_report_thr", 64'(threshold), 0);
      tick();
    end
    thr_ack = 1'b1;
    wait_done("t3", d);
    sweep_totals("t3");
    tick();

    // Reset in ISSUE at threshold 2, then a clean restart.
    clr_counts();
    push_sweep();
    pulse_start(s);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (hist_rd_en && threshold == 2'd2 && hist_rd_addr == 2'd0) found = 1'b1;
    end
    if (!found) timeout("t4_find");
    tick();
    bin_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_in_issue", 64'(bin_valid), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    zero_outputs("t4");
    chk("t4_xfers_before", 64'(n_xfer), SKIP ? 6 : 8);
    tick();
    reset = 1'b0; bin_ready = 1'b1;
    exp_q.delete();
    clr_counts();
    push_sweep();
    pulse_start(s);
    @(negedge clk);
    chk("t4_restart_clear", 64'(acc_clear), 1);
    chk("t4_restart_thr", 64'(threshold), 0);
    wait_done("t4", d);
    chk("t4_latency", 64'(d - s), 64'(SWEEP_LEN));
    sweep_totals("t4");
    tick();

    // start held high through the sweep and the done cycle: ignored throughout.
    clr_counts(); gap_chk = 1'b1;
    push_sweep();
    pulse_start(s);
    repeat (20) tick();
    start = 1'b1;
    wait_done("t5", d);
    chk("t5_latency", 64'(d - s), 64'(SWEEP_LEN));
    tick();
    start = 1'b0;
    sweep_totals("t5");
    gap_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
